// File: rtl/rxuart_cfg.sv
// rxuart_cfg: parametrised asynchronous serial receiver.
// The line is synchronised, sampled at OVERSAMPLE ticks per bit and
// majority-voted at mid-bit. Each finished word goes into a one-entry
// holding register with its parity and framing status.
//
// Handshake: rx_valid rises when a word is loaded and stays high until a
// cycle with rx_valid && rx_ready. A word that finishes while the register
// still holds an unconsumed word is dropped, and overrun pulses for one cycle.
module rxuart_cfg #(
    parameter int CLOCK_DIVIDE = 312,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 is_receiving,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    localparam int DW = $clog2(CLOCK_DIVIDE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DW-1:0] DIV_LOAD  = DW'(CLOCK_DIVIDE - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_V0      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1      = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    logic                 sync1_q, rs_q;
    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_out_q, ferr_out_q, ovr_q;
    logic                 tick, decide, vote, commit;

    assign tick   = (div_q == '0);
    assign decide = tick && (samp_q == S_DEC);
    assign vote   = (v0_q & v1_q) | (v0_q & rs_q) | (v1_q & rs_q);

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rs_q    <= 1'b1;
        end else begin
            sync1_q <= rx;
            rs_q    <= sync1_q;
        end
    end

    // Receiver state, tick divider, sample/bit counters and frame accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            samp_q  <= '0;
            bit_q   <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic: sample capture, voting decisions and the commit strobe.
    always_comb begin
        state_d = state_q;
        div_d   = tick ? DIV_LOAD : div_q - 1'b1;
        samp_d  = samp_q;
        bit_d   = bit_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        commit  = 1'b0;

        if ((state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) && tick) begin
            samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
            if (samp_q == S_V0) v0_d = rs_q;
            if (samp_q == S_V1) v1_d = rs_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rs_q) begin
                    state_d = S_START;
                    div_d   = DIV_LOAD;
                    samp_d  = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zero_d  = 1'b1;
                end
            end
            S_START: begin
                if (decide) begin
                    state_d = vote ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~vote;
                    if (bit_q == B_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_d  = (^shift_q) ^ vote ^ ODD;
                    zero_d  = zero_q & ~vote;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_d = ferr_q | ~vote;
                    zero_d = zero_q & ~vote;
                    if (bit_q == STOP_LAST) begin
                        commit  = 1'b1;
                        bit_d   = '0;
                        samp_d  = '0;
                        state_d = zero_d ? S_BREAK : S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Leave only after a full bit period of continuous idle line.
                if (!rs_q) begin
                    samp_d = '0;
                end else if (tick) begin
                    if (samp_q == S_LAST) begin
                        state_d = S_IDLE;
                        samp_d  = '0;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One-entry holding register with overrun detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= commit && valid_q && !rx_ready;
            if (commit && (!valid_q || rx_ready)) begin
                data_q     <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_d;
                valid_q    <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign parity_err   = perr_out_q;
    assign frame_err    = ferr_out_q;
    assign overrun      = ovr_q;
    assign break_det    = (state_q == S_BREAK);
    assign is_receiving = (state_q != S_IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rxuart_cfg.sv
// Directed bench for rxuart_cfg: an 8N1 instance (a) and a 7E1 instance (b),
// both at 4 clk per tick and 16 ticks per bit (64 clk per bit).
module tb_rxuart_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, ready_a, ready_b;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_brk, b_busy;
    logic [2:0] a_state, b_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // handshake monitor captures
    int         a_cnt = 0, a_ovr_cnt = 0, a_cap_cyc = 0, b_cnt = 0;
    logic [7:0] a_cap_data = '0;
    logic [6:0] b_cap_data = '0;
    logic       a_cap_perr = 1'b0, a_cap_ferr = 1'b0, b_cap_perr = 1'b0, b_cap_ferr = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rxuart_cfg #(.CLOCK_DIVIDE(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(a_data), .rx_valid(a_valid),
        .rx_ready(ready_a), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr),
        .break_det(a_brk), .is_receiving(a_busy), .dbg_state(a_state)
    );

    rxuart_cfg #(.CLOCK_DIVIDE(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(b_data), .rx_valid(b_valid),
        .rx_ready(ready_b), .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr),
        .break_det(b_brk), .is_receiving(b_busy), .dbg_state(b_state)
    );

    // Record every accepted word and every overrun cycle.
    always @(negedge clk) begin
        if (a_valid && ready_a) begin
            a_cnt      <= a_cnt + 1;
            a_cap_data <= a_data;
            a_cap_perr <= a_perr;
            a_cap_ferr <= a_ferr;
            a_cap_cyc  <= cyc;
        end
        if (a_ovr) a_ovr_cnt <= a_ovr_cnt + 1;
        if (b_valid && ready_b) begin
            b_cnt      <= b_cnt + 1;
            b_cap_data <= b_data;
            b_cap_perr <= b_perr;
            b_cap_ferr <= b_ferr;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    // par < 0 means no parity bit.
    task automatic send_frame(input bit sel, input logic [8:0] d, input int nbits, input int par, input logic stop_v);
        drive(sel, 1'b0);
        wait_clk(64);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, d[i]);
            wait_clk(64);
        end
        if (par >= 0) begin
            drive(sel, par[0]);
            wait_clk(64);
        end
        drive(sel, stop_v);
        wait_clk(64);
        drive(sel, 1'b1);
        wait_clk(16);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        n_vec++; if (a_data !== 8'h00) begin n_err++; $display("FAIL rst_a_data got %h want 00", a_data); end
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid got %b want 0", a_valid); end
        n_vec++; if (a_perr !== 1'b0) begin n_err++; $display("FAIL rst_a_perr got %b want 0", a_perr); end
        n_vec++; if (a_ferr !== 1'b0) begin n_err++; $display("FAIL rst_a_ferr got %b want 0", a_ferr); end
        n_vec++; if (a_ovr !== 1'b0) begin n_err++; $display("FAIL rst_a_ovr got %b want 0", a_ovr); end
        n_vec++; if (a_brk !== 1'b0) begin n_err++; $display("FAIL rst_a_brk got %b want 0", a_brk); end
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_a_busy got %b want 0", a_busy); end
        n_vec++; if (a_state !== 3'd0) begin n_err++; $display("FAIL rst_a_state got %0d want 0", a_state); end
        n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_valid got %b want 0", b_valid); end
        n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL rst_b_busy got %b want 0", b_busy); end
    endtask

    task automatic test_8n1();
        int c0, t0, lat;
        c0 = a_cnt; t0 = cyc;
        send_frame(1'b0, 9'h0A5, 8, -1, 1'b1);
        lat = a_cap_cyc - t0;
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL a5_count got %0d want 1", a_cnt - c0); end
        n_vec++; if (a_cap_data !== 8'hA5) begin n_err++; $display("FAIL a5_data got %h want a5", a_cap_data); end
        n_vec++; if (a_cap_perr !== 1'b0) begin n_err++; $display("FAIL a5_perr got %b want 0", a_cap_perr); end
        n_vec++; if (a_cap_ferr !== 1'b0) begin n_err++; $display("FAIL a5_ferr got %b want 0", a_cap_ferr); end
        n_vec++; if (lat < 600 || lat > 640) begin n_err++; $display("FAIL a5_latency got %0d want 600..640", lat); end
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL a5_valid_after got %b want 0", a_valid); end
    endtask

    task automatic test_parity();
        int c0;
        c0 = b_cnt;
        send_frame(1'b1, 9'h041, 7, 1, 1'b1);
        n_vec++; if (b_cnt - c0 !== 1) begin n_err++; $display("FAIL par_bad_count got %0d want 1", b_cnt - c0); end
        n_vec++; if (b_cap_data !== 7'h41) begin n_err++; $display("FAIL par_bad_data got %h want 41", b_cap_data); end
        n_vec++; if (b_cap_perr !== 1'b1) begin n_err++; $display("FAIL par_bad_perr got %b want 1", b_cap_perr); end
        n_vec++; if (b_cap_ferr !== 1'b0) begin n_err++; $display("FAIL par_bad_ferr got %b want 0", b_cap_ferr); end
        send_frame(1'b1, 9'h041, 7, 0, 1'b1);
        n_vec++; if (b_cnt - c0 !== 2) begin n_err++; $display("FAIL par_ok_count got %0d want 2", b_cnt - c0); end
        n_vec++; if (b_cap_data !== 7'h41) begin n_err++; $display("FAIL par_ok_data got %h want 41", b_cap_data); end
        n_vec++; if (b_cap_perr !== 1'b0) begin n_err++; $display("FAIL par_ok_perr got %b want 0", b_cap_perr); end
    endtask

    task automatic test_frame_err();
        int c0;
        c0 = a_cnt;
        send_frame(1'b0, 9'h03C, 8, -1, 1'b0);
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", a_cnt - c0); end
        n_vec++; if (a_cap_data !== 8'h3C) begin n_err++; $display("FAIL ferr_data got %h want 3c", a_cap_data); end
        n_vec++; if (a_cap_ferr !== 1'b1) begin n_err++; $display("FAIL ferr_flag got %b want 1", a_cap_ferr); end
        n_vec++; if (a_brk !== 1'b0) begin n_err++; $display("FAIL ferr_brk got %b want 0", a_brk); end
        wait_clk(100);
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL ferr_idle got %b want 0", a_busy); end
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL ferr_no_extra got %0d want 1", a_cnt - c0); end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = a_cnt;
        rx_a = 1'b0;
        wait_clk(10);
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy got %b want 1", a_busy); end
        wait_clk(10);
        rx_a = 1'b1;
        wait_clk(50);
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle got %b want 0", a_busy); end
        n_vec++; if (a_cnt !== c0) begin n_err++; $display("FAIL glitch_count got %0d want %0d", a_cnt, c0); end
        send_frame(1'b0, 9'h055, 8, -1, 1'b1);
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL g55_count got %0d want 1", a_cnt - c0); end
        n_vec++; if (a_cap_data !== 8'h55) begin n_err++; $display("FAIL g55_data got %h want 55", a_cap_data); end
    endtask

    task automatic test_overrun();
        int c0, o0;
        ready_a = 1'b0;
        c0 = a_cnt; o0 = a_ovr_cnt;
        send_frame(1'b0, 9'h011, 8, -1, 1'b1);
        n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid1 got %b want 1", a_valid); end
        n_vec++; if (a_data !== 8'h11) begin n_err++; $display("FAIL ovr_held1 got %h want 11", a_data); end
        send_frame(1'b0, 9'h022, 8, -1, 1'b1);
        n_vec++; if (a_ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", a_ovr_cnt - o0); end
        n_vec++; if (a_data !== 8'h11) begin n_err++; $display("FAIL ovr_held2 got %h want 11", a_data); end
        n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid2 got %b want 1", a_valid); end
        n_vec++; if (a_cnt !== c0) begin n_err++; $display("FAIL ovr_no_accept got %0d want %0d", a_cnt, c0); end
        @(posedge clk);
        #1 ready_a = 1'b1;
        wait_clk(4);
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL ovr_consume_count got %0d want 1", a_cnt - c0); end
        n_vec++; if (a_cap_data !== 8'h11) begin n_err++; $display("FAIL ovr_consume_data got %h want 11", a_cap_data); end
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_clr got %b want 0", a_valid); end
    endtask

    task automatic test_break();
        int c0;
        c0 = a_cnt;
        rx_a = 1'b0;
        wait_clk(700);
        n_vec++; if (a_brk !== 1'b1) begin n_err++; $display("FAIL brk_on got %b want 1", a_brk); end
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL brk_count got %0d want 1", a_cnt - c0); end
        n_vec++; if (a_cap_data !== 8'h00) begin n_err++; $display("FAIL brk_data got %h want 00", a_cap_data); end
        n_vec++; if (a_cap_ferr !== 1'b1) begin n_err++; $display("FAIL brk_ferr got %b want 1", a_cap_ferr); end
        wait_clk(260);
        rx_a = 1'b1;
        wait_clk(32);
        n_vec++; if (a_brk !== 1'b1) begin n_err++; $display("FAIL brk_hold got %b want 1", a_brk); end
        wait_clk(80);
        n_vec++; if (a_brk !== 1'b0) begin n_err++; $display("FAIL brk_off got %b want 0", a_brk); end
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL brk_idle got %b want 0", a_busy); end
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL brk_no_extra got %0d want 1", a_cnt - c0); end
    endtask

    task automatic test_reset_mid();
        int c0;
        ready_a = 1'b0;
        send_frame(1'b0, 9'h099, 8, -1, 1'b1);
        n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL rm_held got %b want 1", a_valid); end
        rx_a = 1'b0;
        wait_clk(200);
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL rm_busy got %b want 1", a_busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", a_valid); end
        n_vec++; if (a_data !== 8'h00) begin n_err++; $display("FAIL rm_data got %h want 00", a_data); end
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rm_busy0 got %b want 0", a_busy); end
        n_vec++; if (a_brk !== 1'b0) begin n_err++; $display("FAIL rm_brk got %b want 0", a_brk); end
        n_vec++; if (a_ferr !== 1'b0) begin n_err++; $display("FAIL rm_ferr got %b want 0", a_ferr); end
        rx_a = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        ready_a = 1'b1;
        wait_clk(10);
        c0 = a_cnt;
        send_frame(1'b0, 9'h07E, 8, -1, 1'b1);
        n_vec++; if (a_cnt - c0 !== 1) begin n_err++; $display("FAIL rm7e_count got %0d want 1", a_cnt - c0); end
        n_vec++; if (a_cap_data !== 8'h7E) begin n_err++; $display("FAIL rm7e_data got %h want 7e", a_cap_data); end
        n_vec++; if (a_cap_ferr !== 1'b0) begin n_err++; $display("FAIL rm7e_ferr got %b want 0", a_cap_ferr); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_mid();
        wait_clk(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
